// File: rtl/ro_seq_pkg.sv
// Shared state codes, oscillator identifiers and helpers for the ring-oscillator
// measurement sequencer.
package ro_seq_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_GATE   = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
   localparam logic [2:0] S_ACCUM  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam logic OSC_INV  = 1'b0;
   localparam logic OSC_NAND = 1'b1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // A round always measures the inverter ring first when it is enabled.
   function automatic logic first_osc(input logic [1:0] mask);
      return mask[0] ? OSC_INV : OSC_NAND;
   endfunction

endpackage

// File: rtl/ro_measure_sequencer_if.sv
// Control, oscillator and result-handshake signals of the ring-oscillator
// measurement sequencer.
interface ro_measure_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             continuous;
   logic [1:0]       osc_mask;
   logic [CNT_W-1:0] count;
   logic             osc_en;
   logic             osc_sel;
   logic             cnt_clear;
   logic [CNT_W-1:0] result;
   logic             result_osc;
   logic             result_sat;
   logic             result_valid;
   logic             result_ready;
   logic             busy;
   logic [CNT_W-1:0] min_count;
   logic [CNT_W-1:0] max_count;

   modport master (
      input  start, continuous, osc_mask, count, result_ready,
      output osc_en, osc_sel, cnt_clear, result, result_osc, result_sat,
             result_valid, busy, min_count, max_count
   );

   modport slave (
      output start, continuous, osc_mask, count, result_ready,
      input  osc_en, osc_sel, cnt_clear, result, result_osc, result_sat,
             result_valid, busy, min_count, max_count
   );
endinterface

// File: rtl/ro_seq_timer.sv
// Loadable down-counter shared by the settle, gate and sync phases; zero is
// asserted while the count has run out.
module ro_seq_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              cnt <= '0;
      else if (load)          cnt <= load_val;
      else if (cnt != '0)     cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/ro_measure_sequencer.sv
// Ring-oscillator measurement scheduler: settle, gate, sync and accumulate
// 2^NUM_SAMPLES_LOG2 windows per ring. Define RO_SEQ_MINMAX_EN for min/max tracking.
module ro_measure_sequencer
   import ro_seq_pkg::*;
#(
   parameter int CNT_W            = 16,
   parameter int WIN_CYCLES       = 1000,
   parameter int SETTLE_CYCLES    = 16,
   parameter int SYNC_CYCLES      = 3,
   parameter int NUM_SAMPLES_LOG2 = 3
) (
   input logic                    clk,
   input logic                    reset,
   ro_measure_sequencer_if.master bus
);
   localparam int ACC_W   = CNT_W + NUM_SAMPLES_LOG2;
   localparam int IDX_W   = (NUM_SAMPLES_LOG2 > 0) ? NUM_SAMPLES_LOG2 : 1;
   localparam int MAX_CYC = max3(WIN_CYCLES, SETTLE_CYCLES, SYNC_CYCLES);
   localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << NUM_SAMPLES_LOG2) - 1);

   logic [2:0]       state;
   logic [1:0]       mask_q;
   logic             osc_sel;
   logic [ACC_W-1:0] acc;
   logic [IDX_W-1:0] idx;
   logic             sat;
   logic [CNT_W-1:0] result;
   logic             result_osc;
   logic             result_sat;

   logic             batch_start;
   logic             next_sel;
   logic             last_win;
   logic [ACC_W-1:0] acc_sum;
   logic             sat_nxt;
   logic             tmr_load;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_zero;

   assign last_win = (idx == IDX_LAST);
   assign acc_sum  = acc + ACC_W'(bus.count);
   assign sat_nxt  = sat | (bus.count == '1);

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      batch_start = 1'b0;
      next_sel    = osc_sel;
      if (state == S_IDLE && bus.start && bus.osc_mask != 2'b00) begin
         batch_start = 1'b1;
         next_sel    = first_osc(bus.osc_mask);
      end else if (state == S_DONE && bus.result_ready) begin
         // Rings run in bit order, so only the inverter batch can have a successor.
         if (osc_sel == OSC_INV && mask_q[1]) begin
            batch_start = 1'b1;
            next_sel    = OSC_NAND;
         end else if (bus.continuous) begin
            batch_start = 1'b1;
            next_sel    = first_osc(mask_q);
         end
      end
   end

   always_comb begin
      tmr_load = batch_start || (state == S_ACCUM && !last_win) ||
                 (tmr_zero && (state == S_SETTLE || state == S_GATE));
      case (state)
         S_SETTLE: tmr_val = TMR_W'(WIN_CYCLES - 1);
         S_GATE:   tmr_val = TMR_W'(SYNC_CYCLES - 1);
         default:  tmr_val = TMR_W'(SETTLE_CYCLES - 1);
      endcase
   end

   ro_seq_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         mask_q     <= 2'b00;
         osc_sel    <= OSC_INV;
         acc        <= '0;
         idx        <= '0;
         sat        <= 1'b0;
         result     <= '0;
         result_osc <= 1'b0;
         result_sat <= 1'b0;
      end else if (batch_start) begin
         if (state == S_IDLE) mask_q <= bus.osc_mask;
         osc_sel <= next_sel;
         acc     <= '0;
         idx     <= '0;
         sat     <= 1'b0;
         state   <= S_SETTLE;
      end else begin
         case (state)
            S_IDLE:   ;
            S_SETTLE: if (tmr_zero) state <= S_GATE;
            S_GATE:   if (tmr_zero) state <= S_HOLD;
            S_HOLD:   if (tmr_zero) state <= S_ACCUM;
            S_ACCUM: begin
               acc <= acc_sum;
               sat <= sat_nxt;
               idx <= idx + 1'b1;
               if (last_win) begin
                  result     <= CNT_W'(acc_sum >> NUM_SAMPLES_LOG2);
                  result_osc <= osc_sel;
                  result_sat <= sat_nxt;
                  state      <= S_DONE;
               end else begin
                  state <= S_SETTLE;
               end
            end
            S_DONE:   if (bus.result_ready) state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

`ifdef RO_SEQ_MINMAX_EN
   logic [CNT_W-1:0] min_q, max_q, min_out, max_out, min_nxt, max_nxt;

   assign min_nxt = (bus.count < min_q) ? bus.count : min_q;
   assign max_nxt = (bus.count > max_q) ? bus.count : max_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         min_q   <= '1;
         max_q   <= '0;
         min_out <= '0;
         max_out <= '0;
      end else if (batch_start) begin
         min_q <= '1;
         max_q <= '0;
      end else if (state == S_ACCUM) begin
         min_q <= min_nxt;
         max_q <= max_nxt;
         if (last_win) begin
            min_out <= min_nxt;
            max_out <= max_nxt;
         end
      end
   end

   assign bus.min_count = min_out;
   assign bus.max_count = max_out;
`else
   assign bus.min_count = '0;
   assign bus.max_count = '0;
`endif

   // Outputs decode straight from the state flop so reset drops them at once.
   assign bus.osc_en       = (state == S_SETTLE) || (state == S_GATE);
   assign bus.cnt_clear    = (state == S_IDLE) || (state == S_SETTLE) || (state == S_DONE);
   assign bus.osc_sel      = osc_sel;
   assign bus.result       = result;
   assign bus.result_osc   = result_osc;
   assign bus.result_sat   = result_sat;
   assign bus.result_valid = (state == S_DONE);
   assign bus.busy         = (state != S_IDLE);
endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Self-checking bench for ro_measure_sequencer: programmed count model plus a
// result scoreboard; min/max expectations follow RO_SEQ_MINMAX_EN.
module tb_ro_measure_sequencer;
   localparam int CNT_W = 16;

   typedef struct {
      logic [CNT_W-1:0] res;
      logic             osc;
      logic             sat;
      logic [CNT_W-1:0] mn;
      logic [CNT_W-1:0] mx;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   ro_measure_sequencer_if #(.CNT_W(CNT_W)) bus ();

   ro_measure_sequencer #(
      .CNT_W            (CNT_W),
      .WIN_CYCLES       (10),
      .SETTLE_CYCLES    (4),
      .SYNC_CYCLES      (3),
      .NUM_SAMPLES_LOG2 (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_err  = 0;
   int n_xfer = 0;
   int run    = 0;
   bit run_chk = 1'b0;

   exp_t             sb[$];
   logic [CNT_W-1:0] win_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Queues the four window counts and the expected averaged result.
   task automatic push_batch(input logic osc, input logic [CNT_W-1:0] c0, c1, c2, c3);
      logic [CNT_W-1:0] c[4];
      logic [CNT_W+1:0] sum;
      exp_t e;
      c = '{c0, c1, c2, c3};
      sum   = '0;
      e.sat = 1'b0;
      e.mn  = '1;
      e.mx  = '0;
      for (int i = 0; i < 4; i++) begin
         sum = sum + (CNT_W+2)'(c[i]);
         if (c[i] == 16'hFFFF) e.sat = 1'b1;
         if (c[i] < e.mn) e.mn = c[i];
         if (c[i] > e.mx) e.mx = c[i];
         win_q.push_back(c[i]);
      end
      e.res = CNT_W'(sum >> 2);
      e.osc = osc;
`ifndef RO_SEQ_MINMAX_EN
      e.mn = '0;
      e.mx = '0;
`endif
      sb.push_back(e);
   endtask

   task automatic wait_xfers(input int target, input int budget);
      int c = 0;
      while (n_xfer < target && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      check("xfer_count", n_xfer, target);
   endtask

   task automatic pulse_start(input logic [1:0] mask);
      @(posedge clk); #1;
      bus.osc_mask = mask;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start    = 1'b0;
   endtask

   // Count model: a new programmed value appears when each window closes.
   always @(negedge bus.osc_en) begin
      if (win_q.size() > 0) bus.count = win_q.pop_front();
   end

   always @(negedge clk) begin
      if (!reset && bus.result_valid && bus.result_ready) begin
         n_xfer++;
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("result", bus.result, e.res);
            check("result_osc", bus.result_osc, e.osc);
            check("result_sat", bus.result_sat, e.sat);
            check("min_count", bus.min_count, e.mn);
            check("max_count", bus.max_count, e.mx);
         end
      end
   end

   always @(negedge clk) begin
      if (run_chk) begin
         if (bus.osc_en) run++;
         else if (run > 0) begin
            check("osc_en_run", run, 14);
            run = 0;
         end
      end
   end

   initial begin
      int cyc;
      int base;
      bus.start        = 1'b0;
      bus.continuous   = 1'b0;
      bus.osc_mask     = 2'b00;
      bus.count        = '0;
      bus.result_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_osc_en", bus.osc_en, 0);
      check("rst_cnt_clear", bus.cnt_clear, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_valid", bus.result_valid, 0);
      check("rst_result", bus.result, 0);
      check("rst_osc_sel", bus.osc_sel, 0);
      reset = 1'b0;

      // Single inverter ring with latency and osc_en window checks.
      push_batch(1'b0, 16'd100, 16'd102, 16'd98, 16'd100);
      run = 0;
      run_chk = 1'b1;
      @(posedge clk); #1;
      bus.osc_mask = 2'b01;
      bus.start    = 1'b1;
      @(posedge clk);
      cyc = 1;
      #1 bus.start = 1'b0;
      while (!bus.result_valid && cyc < 300) begin
         @(posedge clk); cyc++; #1;
      end
      check("valid_latency", cyc, 73);
      check("osc_sel_inv", bus.osc_sel, 0);
      wait_xfers(1, 20);
      repeat (2) @(posedge clk);
      #1;
      run_chk = 1'b0;
      check("idle_after_single", bus.busy, 0);

      // Both rings in order with ready held high.
      push_batch(1'b0, 16'd50, 16'd50, 16'd50, 16'd50);
      push_batch(1'b1, 16'd200, 16'd200, 16'd200, 16'd200);
      pulse_start(2'b11);
      wait_xfers(3, 400);
      repeat (2) @(posedge clk);
      #1;
      check("idle_after_dual", bus.busy, 0);

      // Backpressure in DONE.
      bus.result_ready = 1'b0;
      push_batch(1'b0, 16'd100, 16'd100, 16'd100, 16'd100);
      pulse_start(2'b01);
      cyc = 0;
      while (!bus.result_valid && cyc < 200) begin
         @(posedge clk); cyc++; #1;
      end
      check("bp_valid_seen", bus.result_valid, 1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         check("bp_valid", bus.result_valid, 1);
         check("bp_result", bus.result, 16'd100);
         check("bp_osc_en", bus.osc_en, 0);
      end
      check("bp_no_xfer", n_xfer, 3);
      bus.result_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_valid_drop", bus.result_valid, 0);
      repeat (3) @(posedge clk);
      #1;
      check("bp_single_xfer", n_xfer, 4);

      // Saturated window.
      push_batch(1'b0, 16'hFFFF, 16'd100, 16'd100, 16'd100);
      pulse_start(2'b01);
      wait_xfers(5, 200);
      check("sat_value", bus.result, 16'h404A);

      // Reset during GATE drops outputs without a clock edge.
      pulse_start(2'b01);
      repeat (6) @(posedge clk);
      #1;
      check("gate_osc_en", bus.osc_en, 1);
      check("gate_cnt_clear", bus.cnt_clear, 0);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("abort_osc_en", bus.osc_en, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_valid", bus.result_valid, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      pulse_start(2'b00);
      repeat (4) @(posedge clk);
      #1;
      check("zero_mask_busy", bus.busy, 0);
      check("zero_mask_osc_en", bus.osc_en, 0);

      // Continuous NAND-only rounds, then stop after the current round.
      base = n_xfer;
      bus.continuous = 1'b1;
      for (int i = 0; i < 3; i++)
         push_batch(1'b1, 16'd90, 16'd110, 16'd100, 16'd100);
      pulse_start(2'b10);
      wait_xfers(base + 2, 400);
      bus.continuous = 1'b0;
      check("cont_busy", bus.busy, 1);
      wait_xfers(base + 3, 200);
      repeat (3) @(posedge clk);
      #1;
      check("cont_idle", bus.busy, 0);
      check("sb_drained", sb.size(), 0);
      check("win_drained", win_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
